gtout_decode: RTL and testbench
===============================

// Module: gtout_decode
// PURPOSE
//  Upstream stage of the VGA scan-doubler. Samples the Gigatron OUT register byte every clk1
//  (6.25 MHz pixel clock) and decodes it into 4-bit RGB plus active-low syncs. Tracks beam
//  position (pix_x, line_y), flags the captured window and judges timing lock, so the
//  frame-buffer writer consumes clean, pre-qualified pixels instead of raw port bits.
// PARAMETERS
//  LINE_CLKS   200  nominal clk1 cycles per scanline (hs fall to hs fall)
//  LINE_TOL    2    allowed |line_len - LINE_CLKS| before a line counts as bad
//  FRAME_LINES 521  nominal scanlines per frame (vs fall to vs fall)
//  FRAME_TOL   4    allowed |lines - FRAME_LINES| before a frame counts as bad
//  LOCK_FRAMES 2    consecutive good frames needed to reach LOCKED
//  PIX_FIRST   12   first captured pix_x;  PIX_COUNT  160  captured pixels per line
//  LINE_FIRST  25   first captured line_y; LINE_COUNT 32   captured lines per frame
// PORTS
//  clk1            in   1   Gigatron pixel clock; only clock
//  reset           in   1   synchronous, active-high
//  out_byte        in   8   OUT reg: [7]=VS_n [6]=HS_n [5:4]=B [3:2]=G [1:0]=R
//  gigatron_vga_r  out  4   red   {R,R}
//  gigatron_vga_g  out  4   green {G,G}
//  gigatron_vga_b  out  4   blue  {B,B}
//  gigatron_vga_hs out  1   registered out_byte[6], active low
//  gigatron_vga_vs out  1   registered out_byte[7], active low
//  hs_fall         out  1   1-cycle pulse: HS_n 1->0
//  vs_fall         out  1   1-cycle pulse: VS_n 1->0
//  pix_x           out  8   clk1 cycles since last hs_fall, saturates at 255
//  line_y          out  10  hs_falls since last vs_fall, saturates at 1023
//  line_len        out  8   length of last complete line (cycles)
//  pix_valid       out  1   pix_x and line_y both inside capture window
//  locked          out  1   FSM in LOCKED
//  sync_err        out  1   1-cycle pulse on every LOCKED->SEARCH drop
// BEHAVIOUR
//  - Reset: rgb=0, hs=vs=1, pulses=0, pix_x=line_y=line_len=0, pix_valid=0, locked=0,
//    FSM=SEARCH, prev-sync regs=1 (no fake edge on first cycle), good-frame cnt=0.
//  - Latency: every output is registered; out_byte at edge N appears on outputs after edge N+1.
//    Edge detect compares out_byte with previous sample, so pulses align with decoded syncs.
//  - pix_x: 0 in the cycle hs_fall is high, else +1, hold at 255. line_len <= pix_x_prev+1 on
//    hs_fall (saturate 255); first hs_fall after reset is not a valid measurement.
//  - line_y: 0 when vs_fall high (priority over simultaneous hs_fall); else +1 on hs_fall.
//  - pix_valid = PIX_FIRST<=pix_x<PIX_FIRST+PIX_COUNT && LINE_FIRST<=line_y<LINE_FIRST+LINE_COUNT,
//    computed from the next-state counters so it aligns with the same output cycle.
//  - Frame line count = line_y value at vs_fall (pre-clear), plus 1 if hs_fall coincides.
//  - FSM SEARCH: wait vs_fall -> CHECK, good cnt=0.
//  - CHECK: bad line (valid measurement, out of tol) -> SEARCH. vs_fall: bad frame -> SEARCH;
//    good frame -> cnt+1; cnt reaching LOCK_FRAMES -> LOCKED.
//  - LOCKED: bad line, bad frame or timeout -> SEARCH with sync_err pulse same cycle locked drops.
//  - Timeout: pix_x reaching 2*LINE_CLKS (saturating 255 counts as reached) in CHECK/LOCKED -> SEARCH.
//  - Simultaneous bad line and vs_fall in CHECK: bad line wins -> SEARCH.
//  - reset mid-frame: all state to reset values next edge; relock needs full LOCK_FRAMES again.
// TESTING
//  1 reset, out_byte=8'hC0 const -> hs=vs=1, rgb=0, no pulses, locked=0 for 1000 cycles.
//  2 out_byte=8'hC0|6'b10_01_11 -> next cycle r=4'hF, g=4'h5, b=4'hA, pix_x counting.
//  3 nominal timing 200 clk/line, 521 lines, HS low 24 clk, VS low 2 lines -> locked=1 right
//    after 2nd good vs_fall following first vs_fall; pix_valid exactly 160x32 cycles per frame.
//  4 while locked, one line of 205 clocks -> sync_err 1 cycle at that hs_fall, locked=0,
//    relock after 2 good frames.
//  5 while locked, HS held high 400 clocks -> locked drops when pix_x hits 255, sync_err pulses.
//  6 hs_fall and vs_fall same cycle -> line_y=0, pix_x=0, line_len updated; assert reset at
//    line 300 -> all outputs return to reset values next edge.

Source files
------------

// File: rtl/gtout_decode_if.sv
// Bundles the Gigatron OUT byte with the decoded pixel/sync/beam/lock outputs.
// Latency: none, wiring only.
// Backpressure: none; the pixel stream runs free at clk1 and cannot be stalled.
// Ports: out_byte (source -> decoder); decoded rgb, syncs, edge pulses,
// beam position, line length, capture window, lock status (decoder -> consumer).
interface gtout_decode_if;
    logic [7:0] out_byte;
    logic [3:0] gigatron_vga_r;
    logic [3:0] gigatron_vga_g;
    logic [3:0] gigatron_vga_b;
    logic       gigatron_vga_hs;
    logic       gigatron_vga_vs;
    logic       hs_fall;
    logic       vs_fall;
    logic [7:0] pix_x;
    logic [9:0] line_y;
    logic [7:0] line_len;
    logic       pix_valid;
    logic       locked;
    logic       sync_err;

    // Source side: drives the raw OUT byte and observes the decoded stream.
    modport master (
        output out_byte,
        input  gigatron_vga_r, gigatron_vga_g, gigatron_vga_b,
        input  gigatron_vga_hs, gigatron_vga_vs, hs_fall, vs_fall,
        input  pix_x, line_y, line_len, pix_valid, locked, sync_err
    );

    // Decoder side.
    modport slave (
        input  out_byte,
        output gigatron_vga_r, gigatron_vga_g, gigatron_vga_b,
        output gigatron_vga_hs, gigatron_vga_vs, hs_fall, vs_fall,
        output pix_x, line_y, line_len, pix_valid, locked, sync_err
    );
endinterface

// File: rtl/gtout_decode.sv
// Decodes the Gigatron OUT byte into 4-bit RGB + syncs, tracks beam position and judges sync lock.
// Latency: one clk1; out_byte sampled at an edge is visible on every output right after that edge.
// Backpressure: none; one sample per clk1, outputs are free-running.
// Ports: clk1 (only clock), reset (sync, active high), bus (slave modport: out_byte in;
// rgb, hs/vs, hs_fall/vs_fall, pix_x, line_y, line_len, pix_valid, locked, sync_err out).
module gtout_decode #(
    parameter int LINE_CLKS   = 200,
    parameter int LINE_TOL    = 2,
    parameter int FRAME_LINES = 521,
    parameter int FRAME_TOL   = 4,
    parameter int LOCK_FRAMES = 2,
    parameter int PIX_FIRST   = 12,
    parameter int PIX_COUNT   = 160,
    parameter int LINE_FIRST  = 25,
    parameter int LINE_COUNT  = 32
) (
    input  logic          clk1,
    input  logic          reset,
    gtout_decode_if.slave bus
);

    // A stalled line is declared after two nominal line times; pix_x saturates
    // at 255, so when that limit is out of range the saturation point stands in.
    localparam int          TO_LIM = (2 * LINE_CLKS > 255) ? 255 : 2 * LINE_CLKS;
    localparam logic [7:0]  TO_V   = 8'(TO_LIM);
    localparam logic [8:0]  LEN_LO = 9'(LINE_CLKS - LINE_TOL);
    localparam logic [8:0]  LEN_HI = 9'(LINE_CLKS + LINE_TOL);
    localparam logic [10:0] FRM_LO = 11'(FRAME_LINES - FRAME_TOL);
    localparam logic [10:0] FRM_HI = 11'(FRAME_LINES + FRAME_TOL);
    localparam logic [8:0]  PX_LO  = 9'(PIX_FIRST);
    localparam logic [8:0]  PX_HI  = 9'(PIX_FIRST + PIX_COUNT);
    localparam logic [10:0] LY_LO  = 11'(LINE_FIRST);
    localparam logic [10:0] LY_HI  = 11'(LINE_FIRST + LINE_COUNT);
    localparam int          CW     = $clog2(LOCK_FRAMES + 1) + 1;
    localparam logic [CW-1:0] LOCK_V = CW'(LOCK_FRAMES);

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_CHECK  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    logic [3:0]    r_q, r_d, g_q, g_d, b_q, b_d;
    logic          hs_q, hs_d, vs_q, vs_d;
    logic          hs_fall_q, hs_fall_d, vs_fall_q, vs_fall_d;
    logic [7:0]    pix_x_q, pix_x_d;
    logic [9:0]    line_y_q, line_y_d;
    logic [7:0]    line_len_q, line_len_d;
    logic          pix_valid_q, pix_valid_d;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] good_q, good_d;
    logic          locked_q, locked_d;
    logic          sync_err_q, sync_err_d;
    logic          seen_hs_q, seen_hs_d;

    logic [8:0]    line_meas;
    logic [7:0]    len_sat;
    logic [10:0]   frame_lines;
    logic [CW-1:0] good_inc;
    logic          bad_line, bad_frame, timeout, drop;

    always_comb begin
        r_d = {bus.out_byte[1:0], bus.out_byte[1:0]};
        g_d = {bus.out_byte[3:2], bus.out_byte[3:2]};
        b_d = {bus.out_byte[5:4], bus.out_byte[5:4]};
        hs_d = bus.out_byte[6];
        vs_d = bus.out_byte[7];

        // hs_q/vs_q double as the previous sample, so the pulses line up
        // with the decoded sync outputs.
        hs_fall_d = hs_q & ~bus.out_byte[6];
        vs_fall_d = vs_q & ~bus.out_byte[7];

        if (hs_fall_d) begin
            pix_x_d = 8'd0;
        end else if (pix_x_q == 8'hFF) begin
            pix_x_d = 8'hFF;
        end else begin
            pix_x_d = pix_x_q + 8'd1;
        end

        // Line length = cycles from previous hs_fall to this one.
        line_meas = {1'b0, pix_x_q} + 9'd1;
        len_sat   = line_meas[8] ? 8'hFF : line_meas[7:0];

        // The first hs_fall after reset ends a partial line, so only later
        // ones give a measurement.
        line_len_d = line_len_q;
        seen_hs_d  = seen_hs_q | hs_fall_d;
        bad_line   = 1'b0;
        if (hs_fall_d && seen_hs_q) begin
            line_len_d = len_sat;
            bad_line   = ({1'b0, len_sat} < LEN_LO) || ({1'b0, len_sat} > LEN_HI);
        end

        if (vs_fall_d) begin
            line_y_d = 10'd0;
        end else if (hs_fall_d && line_y_q != 10'h3FF) begin
            line_y_d = line_y_q + 10'd1;
        end else begin
            line_y_d = line_y_q;
        end

        // A coincident hs_fall closes the last line of the frame too.
        frame_lines = {1'b0, line_y_q} + {10'd0, hs_fall_d};
        bad_frame   = (frame_lines < FRM_LO) || (frame_lines > FRM_HI);

        pix_valid_d = ({1'b0, pix_x_d} >= PX_LO) && ({1'b0, pix_x_d} < PX_HI) &&
                      ({1'b0, line_y_d} >= LY_LO) && ({1'b0, line_y_d} < LY_HI);

        timeout  = (pix_x_d >= TO_V);
        drop     = bad_line | timeout | (vs_fall_d & bad_frame);
        good_inc = good_q + CW'(1);

        state_d    = state_q;
        good_d     = good_q;
        sync_err_d = 1'b0;
        case (state_q)
            ST_SEARCH: begin
                if (vs_fall_d) begin
                    state_d = ST_CHECK;
                    good_d  = '0;
                end
            end
            ST_CHECK: begin
                // A bad line or stall outranks a frame boundary in the same cycle.
                if (drop) begin
                    state_d = ST_SEARCH;
                    good_d  = '0;
                end else if (vs_fall_d) begin
                    good_d = good_inc;
                    if (good_inc >= LOCK_V) begin
                        state_d = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                if (drop) begin
                    state_d    = ST_SEARCH;
                    good_d     = '0;
                    sync_err_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_SEARCH;
                good_d  = '0;
            end
        endcase
        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk1) begin
        if (reset) begin
            r_q         <= 4'd0;
            g_q         <= 4'd0;
            b_q         <= 4'd0;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            hs_fall_q   <= 1'b0;
            vs_fall_q   <= 1'b0;
            pix_x_q     <= 8'd0;
            line_y_q    <= 10'd0;
            line_len_q  <= 8'd0;
            pix_valid_q <= 1'b0;
            state_q     <= ST_SEARCH;
            good_q      <= '0;
            locked_q    <= 1'b0;
            sync_err_q  <= 1'b0;
            seen_hs_q   <= 1'b0;
        end else begin
            r_q         <= r_d;
            g_q         <= g_d;
            b_q         <= b_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            hs_fall_q   <= hs_fall_d;
            vs_fall_q   <= vs_fall_d;
            pix_x_q     <= pix_x_d;
            line_y_q    <= line_y_d;
            line_len_q  <= line_len_d;
            pix_valid_q <= pix_valid_d;
            state_q     <= state_d;
            good_q      <= good_d;
            locked_q    <= locked_d;
            sync_err_q  <= sync_err_d;
            seen_hs_q   <= seen_hs_d;
        end
    end

    assign bus.gigatron_vga_r  = r_q;
    assign bus.gigatron_vga_g  = g_q;
    assign bus.gigatron_vga_b  = b_q;
    assign bus.gigatron_vga_hs = hs_q;
    assign bus.gigatron_vga_vs = vs_q;
    assign bus.hs_fall         = hs_fall_q;
    assign bus.vs_fall         = vs_fall_q;
    assign bus.pix_x           = pix_x_q;
    assign bus.line_y          = line_y_q;
    assign bus.line_len        = line_len_q;
    assign bus.pix_valid       = pix_valid_q;
    assign bus.locked          = locked_q;
    assign bus.sync_err        = sync_err_q;

endmodule

// File: tb/tb_gtout_decode.sv
// Bench for gtout_decode: random pixel data over synthetic scan timing, checked every cycle
// against an event-level reference model, plus targeted lock/relock/reset checks.
// Timing is scaled down (130-clock lines, 21-line frames) to keep the run short.
module tb_gtout_decode;
    localparam int LC  = 130;
    localparam int LT  = 2;
    localparam int FL  = 21;
    localparam int FT  = 2;
    localparam int LF  = 2;
    localparam int PF  = 12;
    localparam int PC  = 100;
    localparam int LYF = 5;
    localparam int LYC = 8;
    localparam int HS_LOW = 16;

    logic clk1 = 1'b0;
    logic reset;
    always #5 clk1 = ~clk1;

    gtout_decode_if bus ();

    gtout_decode #(
        .LINE_CLKS(LC), .LINE_TOL(LT), .FRAME_LINES(FL), .FRAME_TOL(FT),
        .LOCK_FRAMES(LF), .PIX_FIRST(PF), .PIX_COUNT(PC),
        .LINE_FIRST(LYF), .LINE_COUNT(LYC)
    ) dut (
        .clk1 (clk1),
        .reset(reset),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: beam position from the time of the last sync event,
    // lock from counting good frames since the first frame boundary seen
    // after the last disqualifying event.
    int   m_t = 0;
    int   m_last_hs = 0;
    int   m_lines = 0;
    int   m_good = 0;
    bit   m_have_hs = 0;
    bit   m_anch = 0;
    bit   m_prev_hs = 1;
    bit   m_prev_vs = 1;
    logic [7:0] m_ll = 8'd0;
    logic [63:0] m_exp;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_step(input logic [7:0] b, input logic r);
        bit hf, vf, bad_line, bad_frame, tmo, was_locked, lk, se, pv;
        int px, ly, len, frame_lines;
        if (r) begin
            m_last_hs = m_t;
            m_have_hs = 0;
            m_lines   = 0;
            m_ll      = 8'd0;
            m_anch    = 0;
            m_good    = 0;
            m_prev_hs = 1;
            m_prev_vs = 1;
            m_exp = {19'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0,
                     8'd0, 10'd0, 8'd0, 1'b0, 1'b0, 1'b0};
        end else begin
            hf = m_prev_hs && !b[6];
            vf = m_prev_vs && !b[7];
            bad_line = 0;
            if (hf) begin
                len = imin(255, m_t - m_last_hs);
                if (m_have_hs) begin
                    m_ll = 8'(len);
                    bad_line = iabs(len - LC) > LT;
                end
                m_have_hs = 1;
                m_last_hs = m_t;
            end
            frame_lines = m_lines + int'(hf);
            if (vf) m_lines = 0;
            else if (hf) m_lines++;
            px = imin(255, m_t - m_last_hs);
            ly = imin(1023, m_lines);
            tmo = px >= imin(255, 2 * LC);
            bad_frame = iabs(frame_lines - FL) > FT;
            was_locked = m_anch && (m_good >= LF);
            if (m_anch && (bad_line || tmo || (vf && bad_frame))) begin
                m_anch = 0;
                m_good = 0;
            end else if (vf) begin
                if (!m_anch) begin
                    m_anch = 1;
                    m_good = 0;
                end else begin
                    m_good++;
                end
            end
            lk = m_anch && (m_good >= LF);
            se = was_locked && !lk;
            pv = (px >= PF) && (px < PF + PC) && (ly >= LYF) && (ly < LYF + LYC);
            m_prev_hs = b[6];
            m_prev_vs = b[7];
            m_exp = {19'd0, {b[1:0], b[1:0]}, {b[3:2], b[3:2]}, {b[5:4], b[5:4]},
                     b[6], b[7], hf, vf, 8'(px), 10'(ly), m_ll, pv, lk, se};
        end
        m_t++;
    endtask

    function automatic logic [63:0] dut_vec();
        return {19'd0, bus.gigatron_vga_r, bus.gigatron_vga_g, bus.gigatron_vga_b,
                bus.gigatron_vga_hs, bus.gigatron_vga_vs, bus.hs_fall, bus.vs_fall,
                bus.pix_x, bus.line_y, bus.line_len, bus.pix_valid, bus.locked,
                bus.sync_err};
    endfunction

    int pv_cnt = 0;
    int se_cnt = 0;
    logic first_locked;

    task automatic step(input logic [7:0] b, input logic r);
        @(negedge clk1);
        bus.out_byte = b;
        reset = r;
        @(posedge clk1);
        model_step(b, r);
        #1;
        check_eq("outs", dut_vec(), m_exp);
        pv_cnt += int'(bus.pix_valid);
        se_cnt += int'(bus.sync_err);
    endtask

    // One frame: VS low for the first two lines, each line opens with HS low.
    // Line bad_at gets length bad_len; a reset is injected at (rst_line, 50).
    task automatic do_frame(input int nl, input int bad_at, input int bad_len, input int rst_line);
        int len;
        logic [7:0] b;
        logic r;
        pv_cnt = 0;
        se_cnt = 0;
        for (int l = 0; l < nl; l++) begin
            len = (l == bad_at) ? bad_len : LC + int'($urandom_range(0, 2 * LT)) - LT;
            for (int c = 0; c < len; c++) begin
                b = {(l < 2) ? 1'b0 : 1'b1, (c < HS_LOW) ? 1'b0 : 1'b1, 6'($urandom)};
                r = (l == rst_line) && (c == 50);
                step(b, r);
                if (l == 0 && c == 0) begin
                    first_locked = bus.locked;
                    check_eq("coinc_hs_fall", 64'(bus.hs_fall), 64'd1);
                    check_eq("coinc_vs_fall", 64'(bus.vs_fall), 64'd1);
                    check_eq("coinc_line_y", 64'(bus.line_y), 64'd0);
                    check_eq("coinc_pix_x", 64'(bus.pix_x), 64'd0);
                end
                if (r) begin
                    check_eq("rst_pix_x", 64'(bus.pix_x), 64'd0);
                    check_eq("rst_line_y", 64'(bus.line_y), 64'd0);
                    check_eq("rst_locked", 64'(bus.locked), 64'd0);
                    check_eq("rst_syncs", 64'({bus.gigatron_vga_hs, bus.gigatron_vga_vs}), 64'd3);
                    check_eq("rst_rgb", 64'({bus.gigatron_vga_r, bus.gigatron_vga_g,
                                             bus.gigatron_vga_b}), 64'd0);
                end
            end
        end
    endtask

    function automatic int nominal_lines();
        return FL + int'($urandom_range(0, 2 * FT)) - FT;
    endfunction

    initial begin
        reset = 1'b1;
        bus.out_byte = 8'hC0;
        for (int i = 0; i < 3; i++) step(8'hC0, 1'b1);

        // Idle bus with both syncs high: nothing should happen.
        for (int i = 0; i < 1000; i++) step(8'hC0, 1'b0);
        check_eq("idle_locked", 64'(bus.locked), 64'd0);
        check_eq("idle_pix_x_sat", 64'(bus.pix_x), 64'd255);

        // Colour decode.
        step(8'hC0 | 8'b0010_0111, 1'b0);
        check_eq("rgb_r", 64'(bus.gigatron_vga_r), 64'hF);
        check_eq("rgb_g", 64'(bus.gigatron_vga_g), 64'h5);
        check_eq("rgb_b", 64'(bus.gigatron_vga_b), 64'hA);
        for (int i = 0; i < 20; i++) step({2'b11, 6'($urandom)}, 1'b0);

        // Acquire lock from nominal timing.
        do_frame(nominal_lines(), -1, 0, -1);
        check_eq("f1_pix_valid", 64'(pv_cnt), 64'(PC * LYC));
        do_frame(nominal_lines(), -1, 0, -1);
        check_eq("f2_pix_valid", 64'(pv_cnt), 64'(PC * LYC));
        check_eq("f2_not_locked", 64'(bus.locked), 64'd0);
        do_frame(nominal_lines(), -1, 0, -1);
        check_eq("f3_locked_at_vs", 64'(first_locked), 64'd1);
        check_eq("f3_pix_valid", 64'(pv_cnt), 64'(PC * LYC));
        do_frame(FL, -1, 0, -1);
        check_eq("f4_pix_valid", 64'(pv_cnt), 64'(PC * LYC));
        check_eq("f4_no_err", 64'(se_cnt), 64'd0);

        // Overlong line while locked, then relock.
        do_frame(FL, 10, LC + 7, -1);
        check_eq("badline_err", 64'(se_cnt), 64'd1);
        check_eq("badline_unlocked", 64'(bus.locked), 64'd0);
        do_frame(FL, -1, 0, -1);
        do_frame(FL, -1, 0, -1);
        check_eq("relock1_pending", 64'(bus.locked), 64'd0);
        do_frame(FL, -1, 0, -1);
        check_eq("relock1_locked", 64'(first_locked), 64'd1);

        // HS stuck high for 400 clocks: pix_x saturation counts as timeout.
        do_frame(FL, 6, HS_LOW + 400, -1);
        check_eq("timeout_err", 64'(se_cnt), 64'd1);
        check_eq("timeout_unlocked", 64'(bus.locked), 64'd0);
        do_frame(FL, -1, 0, -1);
        do_frame(FL, -1, 0, -1);
        do_frame(FL, -1, 0, -1);
        check_eq("relock2_locked", 64'(first_locked), 64'd1);

        // Frame with too many lines: drop at the closing vs_fall.
        do_frame(FL + FT + 1, -1, 0, -1);
        check_eq("badframe_no_err_yet", 64'(se_cnt), 64'd0);
        do_frame(FL, -1, 0, -1);
        check_eq("badframe_err", 64'(se_cnt), 64'd1);
        check_eq("badframe_unlocked_at_vs", 64'(first_locked), 64'd0);

        // Reset mid-frame; relock needs the full frame count again.
        do_frame(FL, -1, 0, 10);
        do_frame(FL, -1, 0, -1);
        do_frame(FL, -1, 0, -1);
        check_eq("post_rst_pending", 64'(bus.locked), 64'd0);
        do_frame(FL, -1, 0, -1);
        check_eq("post_rst_locked", 64'(first_locked), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
